// File: rtl/decode_pkg.sv
// Shared definitions for the multicycle control decoder: FSM states, opcode
// and Funct field values, and the ALUControl code points.
package decode_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_LSTART = 4'd10,
        S_LWAIT  = 4'd11,
        S_LWBLO  = 4'd12,
        S_LWBHI  = 4'd13,
        S_TRAP   = 4'd14
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] MUL_PATTERN = 4'b1001;

    // Funct[4:1] command field, data-processing group
    localparam logic [3:0] F_AND   = 4'b0000;
    localparam logic [3:0] F_EOR   = 4'b0001;
    localparam logic [3:0] F_SUB   = 4'b0010;
    localparam logic [3:0] F_ADD   = 4'b0100;
    localparam logic [3:0] F_ADD16 = 4'b1000;
    localparam logic [3:0] F_ADD32 = 4'b1001;
    localparam logic [3:0] F_MUL16 = 4'b1010;
    localparam logic [3:0] F_MUL32 = 4'b1011;
    localparam logic [3:0] F_ORR   = 4'b1100;
    localparam logic [3:0] F_MOV   = 4'b1101;
    localparam logic [3:0] F_LSL   = 4'b1110;

    // Funct[4:1] command field, long-op group (isMul)
    localparam logic [3:0] MF_MUL  = 4'b0000;
    localparam logic [3:0] MF_UMUL = 4'b0100;
    localparam logic [3:0] MF_SMUL = 4'b0110;
    localparam logic [3:0] MF_DIV  = 4'b1000;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_ORR   = 4'h3;
    localparam logic [3:0] ALU_MUL   = 4'h4;
    localparam logic [3:0] ALU_SMUL  = 4'h5;
    localparam logic [3:0] ALU_UMUL  = 4'h6;
    localparam logic [3:0] ALU_DIV   = 4'h7;
    localparam logic [3:0] ALU_EOR   = 4'h8;
    localparam logic [3:0] ALU_MOV   = 4'h9;
    localparam logic [3:0] ALU_LSL   = 4'hA;
    localparam logic [3:0] ALU_ADD16 = 4'hB;
    localparam logic [3:0] ALU_MUL16 = 4'hC;
    localparam logic [3:0] ALU_ADD32 = 4'hD;
    localparam logic [3:0] ALU_MUL32 = 4'hE;

    function automatic logic is_long_mul(input logic [3:0] code);
        return (code == ALU_UMUL) || (code == ALU_SMUL);
    endfunction

endpackage

// File: rtl/decode_alu_dec.sv
// Combinational ALU decoder: maps the Funct command field to an ALUControl
// code, the raw flag-write enables, and an illegal-encoding indication.
module decode_alu_dec
    import decode_pkg::*;
#(
    parameter int ALU_W = 4
) (
    input  logic             is_mul,
    input  logic [3:0]       cmd,
    input  logic             s_bit,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic [1:0]       flag_w,
    output logic             long_mul,
    output logic             illegal
);

    logic [3:0] code;

    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        if (is_mul) begin
            case (cmd)
                MF_MUL:  code = ALU_MUL;
                MF_UMUL: code = ALU_UMUL;
                MF_SMUL: code = ALU_SMUL;
                MF_DIV:  code = ALU_DIV;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (cmd)
                F_ADD:   code = ALU_ADD;
                F_SUB:   code = ALU_SUB;
                F_AND:   code = ALU_AND;
                F_ORR:   code = ALU_ORR;
                F_EOR:   code = ALU_EOR;
                F_MOV:   code = ALU_MOV;
                F_LSL:   code = ALU_LSL;
                F_ADD16: code = ALU_ADD16;
                F_MUL16: code = ALU_MUL16;
                F_ADD32: code = ALU_ADD32;
                F_MUL32: code = ALU_MUL32;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign alu_ctrl = ALU_W'(code);
    assign long_mul = is_mul && is_long_mul(code);
    // Carry/overflow only make sense for the ADD/SUB codes (0 and 1)
    assign flag_w   = {s_bit, s_bit & (alu_ctrl[ALU_W-1:1] == '0)};

endmodule

// File: rtl/decode_mc.sv
// Multicycle control decoder: main FSM, long-op sequencing with watchdog, PC
// logic. Build option DECODE_TRAP_EN routes illegal instructions to TRAP.
module decode_mc
    import decode_pkg::*;
#(
    parameter int ALU_W    = 4,
    parameter int WAIT_W   = 6,
    parameter int WAIT_MAX = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic [3:0]       Mul,
    input  logic             ExDone,
    output logic [1:0]       FlagW,
    output logic             PCS,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [ALU_W-1:0] ALUControl,
    output logic             isMul,
    output logic             longFlag,
    output logic             ExStart,
    output logic             ExAbort,
    output logic             Undef,
    output logic [3:0]       state
);

`ifdef DECODE_TRAP_EN
    localparam state_e ILLEGAL_DEST = S_TRAP;
`else
    localparam state_e ILLEGAL_DEST = S_FETCH;
`endif

    // Counter holds completed LWAIT cycles, so expiry is seen on the last allowed one
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [ALU_W-1:0]  dec_ctrl;
    logic [1:0]        dec_flag_w;
    logic              dec_long_mul;
    logic              dec_illegal;
    logic              alu_op;
    logic              flag_en;
    logic              branch;

    assign isMul = (Op == OP_DP) && (Mul == MUL_PATTERN);

    decode_alu_dec #(
        .ALU_W (ALU_W)
    ) u_alu_dec (
        .is_mul   (isMul),
        .cmd      (Funct[4:1]),
        .s_bit    (Funct[0]),
        .alu_ctrl (dec_ctrl),
        .flag_w   (dec_flag_w),
        .long_mul (dec_long_mul),
        .illegal  (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 1'b0;
        flag_en    = 1'b0;
        branch     = 1'b0;
        longFlag   = 1'b0;
        ExStart    = 1'b0;
        ExAbort    = 1'b0;
        Undef      = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (Op == OP_MEM)      state_d = S_MEMADR;
                else if (Op == OP_BR)  state_d = S_BRANCH;
                else if (Op == OP_ILL) state_d = ILLEGAL_DEST;
                else if (dec_illegal)  state_d = ILLEGAL_DEST;
                else if (isMul)        state_d = S_LSTART;
                else if (Funct[5])     state_d = S_EXECI;
                else                   state_d = S_EXECR;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                MemW    = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_op  = 1'b1;
                flag_en = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                flag_en = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegW    = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_LSTART: begin
                alu_op     = 1'b1;
                ExStart    = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_LWAIT;
            end
            S_LWAIT: begin
                alu_op     = 1'b1;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (ExDone) begin
                    state_d = S_LWBLO;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    ExAbort = 1'b1;
                    state_d = ILLEGAL_DEST;
                end
            end
            S_LWBLO: begin
                RegW    = 1'b1;
                alu_op  = 1'b1;
                flag_en = 1'b1;
                state_d = dec_long_mul ? S_LWBHI : S_FETCH;
            end
            S_LWBHI: begin
                RegW      = 1'b1;
                ResultSrc = 2'b11;
                longFlag  = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef DECODE_TRAP_EN
            S_TRAP: begin
                Undef   = 1'b1;
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    assign ALUControl = alu_op ? dec_ctrl : '0;
    assign FlagW      = flag_en ? dec_flag_w : 2'b00;
    assign PCS        = ((Rd == 4'd15) && RegW) || branch;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_MEM, Op == OP_BR};
    assign state      = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule
